ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  Counterpart of the keyboard receive path: shares the open-collector ps2_clk/ps2_data pins through tri-state enables.
//  Sits beside the input block; the processor output path issues Send with a byte and polls Busy/Done/Error.
// PARAMETERS
//  INHIBIT_CYCLES  5000    Clock cycles ps2_clk is held low before request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  Max cycles without a device clock edge while busy (15 ms @ 50 MHz)
//  CNT_W           20      Width of timing counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES)
// PORTS
//  Clock        in   1  system clock, 50 MHz
//  Reset        in   1  asynchronous, active-low reset
//  Send         in   1  1-cycle start strobe; accepted only when Busy=0
//  SendData     in   8  command byte; captured on the accepted Send
//  ps2_clk_in   in   1  pad value of PS/2 clock (asynchronous)
//  ps2_data_in  in   1  pad value of PS/2 data (asynchronous)
//  ps2_clk_oe   out  1  1 = pull ps2_clk low, 0 = release (pad: oe ? 1'b0 : 1'bz)
//  ps2_data_oe  out  1  1 = pull ps2_data low, 0 = release
//  Busy         out  1  high from accepted Send until Done/Error
//  Done         out  1  1-cycle pulse: frame sent and ACK received
//  Error        out  1  1-cycle pulse: timeout or missing ACK
// BEHAVIOUR
//  Reset (async, Reset=0): state IDLE; ps2_clk_oe=0, ps2_data_oe=0, Busy=0, Done=0, Error=0; counters and shift reg 0.
//  Inputs ps2_clk_in/ps2_data_in pass through a 2-FF synchroniser; falling edge = sync'd clk 1->0; latency 2-3 cycles.
//  Frame: start(0), D0..D7 LSB first, odd parity (parity = ~^SendData), stop(1), device ACK(0).
//  States:
//   IDLE     : Send=1 -> latch {parity,SendData} into 9-bit shifter, bitcnt=0, timer=0, Busy=1, -> INHIBIT.
//   INHIBIT  : clk_oe=1, data_oe=0; timer counts to INHIBIT_CYCLES-1 -> RTS.
//   RTS      : data_oe=1 (start bit), then next cycle clk_oe=0, timer=0 -> XFER.
//   XFER     : on each device falling edge: bitcnt 0..8 -> data_oe = ~shifter[0], shift right; bitcnt 9 -> data_oe=0 (stop).
//              bitcnt increments per edge; after edge 10 (bitcnt==10) -> ACK.
//   ACK      : on next falling edge sample ps2_data_in: 0 -> WAIT_IDLE; 1 -> ERR.
//   WAIT_IDLE: wait until sync'd clk=1 and data=1 -> DONE.
//   DONE     : Done=1 one cycle, Busy=0 -> IDLE.   ERR: Error=1 one cycle, release both lines, Busy=0 -> IDLE.
//  Timer resets on every device falling edge in RTS/XFER/ACK/WAIT_IDLE; reaching TIMEOUT_CYCLES -> ERR.
//  Send while Busy=1 ignored (no re-latch). Send in the cycle of Done/Error ignored; accepted next cycle.
//  Done and Error never asserted together; both 0 outside the terminating cycle.
//  Reset mid-frame: both oe released immediately (async); device times out on its own; no Done/Error issued.
//  Both oe never driven by the block outside INHIBIT..XFER except data_oe during start bit/data bits.
//  Block ignores receive-direction traffic; the receiver must be gated by Busy (no capture while Busy=1).
// STRUCTURE
//  Package ps2_pkg: state encoding localparams (IDLE,INHIBIT,RTS,XFER,ACK,WAIT_IDLE,DONE,ERR),
//   frame bit counts (DATA_BITS=8, FRAME_EDGES=11), default timing constants, odd-parity function.
//  Sub-module ps2_line_sync: 2-FF synchroniser for clk and data plus falling-edge strobe; reused by the receiver.
//  Top: FSM, 9-bit shifter, 4-bit edge counter, CNT_W timer.
// TESTING (bench models a PS/2 device: 12.5 kHz clock, samples data on rising edge, drives ACK)
//  Send=1, SendData=8'hED -> clk low 5000 cycles; device sees 0,1,0,1,1,0,1,1,1, parity 1, stop 1; ACK -> Done pulse once, Busy falls.
//  SendData=8'h00 -> parity bit 1; SendData=8'h01 -> parity 0; both frames complete with Done.
//  Device returns data=1 in ACK slot -> Error pulse, Done stays 0, both oe = 0 afterwards.
//  Device stops clocking after 4th bit -> Error exactly TIMEOUT_CYCLES cycles after last falling edge.
//  Second Send with SendData=8'hFF while Busy -> ignored; transmitted byte remains 8'hED.
//  Reset=0 during XFER -> ps2_clk_oe=ps2_data_oe=0 same cycle, Busy=0; new Send after release transmits normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmit path and its receive-side neighbours.
package ps2_pkg;

  // Transmitter sequencer states, in frame order.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_XFER      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5,
    ST_DONE      = 3'd6,
    ST_ERR       = 3'd7
  } ps2_tx_state_e;

  // Frame geometry: 8 data bits; 11 device falling edges (10 bit slots + ACK).
  localparam int DATA_BITS   = 8;
  localparam int FRAME_EDGES = 11;

  // Default timing at 50 MHz: 100 us inhibit, 15 ms device-clock timeout.
  localparam int DEFAULT_INHIBIT_CYCLES = 5000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 750000;
  localparam int DEFAULT_CNT_W          = 20;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pads plus a falling-edge
// strobe on the synchronised clock. Shared with the keyboard receive path.
module ps2_line_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  // Bit 0 carries the clock pad, bit 1 the data pad.
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       clk_prev_reg;

  // Sync chain resets to the idle (released, high) bus level so leaving reset
  // does not fabricate a falling edge.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      meta_reg     <= 2'b11;
      sync_reg     <= 2'b11;
      clk_prev_reg <= 1'b1;
    end else begin
      meta_reg     <= {data_in, clk_in};
      sync_reg     <= meta_reg;
      clk_prev_reg <= sync_reg[0];
    end
  end

  assign clk_sync  = sync_reg[0];
  assign data_sync = sync_reg[1];
  assign clk_fall  = clk_prev_reg & ~sync_reg[0];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts out one command byte on device clock edges and checks the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = DEFAULT_CNT_W
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DATA_BITS-1:0] SendData,
  input  logic                 ps2_clk_in,
  input  logic                 ps2_data_in,
  output logic                 ps2_clk_oe,
  output logic                 ps2_data_oe,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Error
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  // Edge index at which the stop bit is presented; the next edge is the ACK slot.
  localparam logic [3:0]       STOP_IDX     = 4'(FRAME_EDGES - 2);

  ps2_tx_state_e        state_reg, state_next;
  logic [DATA_BITS:0]   shift_reg, shift_next;
  logic [3:0]           bitcnt_reg, bitcnt_next;
  logic [CNT_W-1:0]     timer_reg, timer_next;
  logic                 data_oe_reg, data_oe_next;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;
  logic timeout_hit;

  ps2_line_sync u_line_sync (
    .Clock     (Clock),
    .Reset     (Reset),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign timeout_hit = (timer_reg == TIMEOUT_LAST);

  // State and datapath registers; async reset releases both lines at once.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bitcnt_reg  <= '0;
      timer_reg   <= '0;
      data_oe_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bitcnt_reg  <= bitcnt_next;
      timer_reg   <= timer_next;
      data_oe_reg <= data_oe_next;
    end
  end

  // Next-state, shifter, edge counter and timer sequencing.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bitcnt_next  = bitcnt_reg;
    timer_next   = timer_reg;
    data_oe_next = data_oe_reg;

    case (state_reg)
      ST_IDLE: begin
        data_oe_next = 1'b0;
        if (Send) begin
          shift_next  = {odd_parity(SendData), SendData};
          bitcnt_next = '0;
          timer_next  = '0;
          state_next  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (timer_reg == INHIBIT_LAST) begin
          timer_next   = '0;
          data_oe_next = 1'b1;           // start bit goes out with RTS
          state_next   = ST_RTS;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end

      ST_RTS: begin
        timer_next = '0;
        state_next = ST_XFER;
      end

      ST_XFER: begin
        if (clk_fall) begin
          timer_next  = '0;
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg < STOP_IDX) begin
            data_oe_next = ~shift_reg[0];
            shift_next   = {1'b0, shift_reg[DATA_BITS:1]};
          end else begin
            data_oe_next = 1'b0;         // stop bit: release data
            state_next   = ST_ACK;
          end
        end else if (timeout_hit) begin
          data_oe_next = 1'b0;
          state_next   = ST_ERR;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end

      ST_ACK: begin
        data_oe_next = 1'b0;
        if (clk_fall) begin
          timer_next = '0;
          state_next = data_sync ? ST_ERR : ST_WAIT_IDLE;
        end else if (timeout_hit) begin
          state_next = ST_ERR;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end

      ST_WAIT_IDLE: begin
        data_oe_next = 1'b0;
        if (clk_sync && data_sync) begin
          state_next = ST_DONE;
        end else if (clk_fall) begin
          timer_next = '0;
        end else if (timeout_hit) begin
          state_next = ST_ERR;
        end else begin
          timer_next = timer_reg + CNT_W'(1);
        end
      end

      ST_DONE: begin
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end

      ST_ERR: begin
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end

      default: begin
        data_oe_next = 1'b0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // Line drives are decoded from state so nothing is pulled outside the
  // inhibit/RTS/transfer window, whatever the data_oe register holds.
  assign ps2_clk_oe  = (state_reg == ST_INHIBIT) || (state_reg == ST_RTS);
  assign ps2_data_oe = data_oe_reg && ((state_reg == ST_RTS) || (state_reg == ST_XFER));
  assign Busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE) && (state_reg != ST_ERR);
  assign Done        = (state_reg == ST_DONE);
  assign Error       = (state_reg == ST_ERR);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: behavioural PS/2 device model plus scoreboard queues for
// transmitted frames and Done/Error outcomes.
module tb_ps2_host_tx;

  localparam int INH  = 50;    // scaled inhibit time
  localparam int TMO  = 400;   // scaled device-clock timeout
  localparam int HALF = 20;    // device clock half period in system cycles

  localparam int RES_DONE = 1;
  localparam int RES_ERR  = 2;

  // Device behaviour per frame.
  localparam int MODE_ACK     = 0;
  localparam int MODE_NACK    = 1;
  localparam int MODE_STALL   = 2;
  localparam int MODE_NOCHECK = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       Send = 1'b0;
  logic [7:0] SendData = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, Busy, Done, Error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  wire  ps2_data_line = ~(ps2_data_oe | dev_data_low);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int dev_mode = MODE_ACK;
  int dev_pulse = 0;
  bit dev_active = 1'b0;

  logic [7:0] exp_byte_q[$];
  int         exp_res_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (20)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Send        (Send),
    .SendData    (SendData),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .Busy        (Busy),
    .Done        (Done),
    .Error       (Error)
  );

  always #10 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, got);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    vectors++;
    if (got < lo || got > hi) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Reference frame as the device should see it: start 0, data LSB first,
  // odd parity, stop 1 (bit 0 of the word = first bit on the wire).
  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b, 1'b0};
  endfunction

  // PS/2 device: measures the inhibit, clocks the frame, samples on rising
  // edges and answers the ACK slot according to dev_mode.
  initial begin : device
    int         inh;
    int         last_fall;
    int         np;
    int         t;
    logic [10:0] obs;
    logic [7:0]  b;
    forever begin
      @(negedge Clock);
      if (Reset && ps2_clk_oe) begin
        dev_active = 1'b1;
        inh = 0;
        while (ps2_clk_oe) begin
          inh++;
          @(negedge Clock);
        end
        // INH cycles of inhibit plus the one RTS cycle with clock still held.
        check("inhibit_len", inh, INH + 1);
        repeat (10) @(negedge Clock);
        obs = '0;
        obs[0] = ps2_data_line;
        last_fall = cyc;
        np = (dev_mode == MODE_STALL) ? 4 : 10;
        for (int p = 1; p <= np; p++) begin
          dev_clk_low = 1'b1;
          last_fall = cyc;
          dev_pulse = p;
          repeat (HALF) @(negedge Clock);
          dev_clk_low = 1'b0;
          obs[p] = ps2_data_line;
          repeat (HALF) @(negedge Clock);
        end
        if (dev_mode == MODE_STALL) begin
          t = 0;
          while (!Error && t < 3 * TMO) begin
            @(negedge Clock);
            t++;
          end
          // Two synchroniser flops plus the registered edge put the host's
          // view of the edge 2..4 cycles behind the pad.
          check_range("timeout_latency", cyc - last_fall, TMO + 2, TMO + 4);
        end else begin
          if (dev_mode != MODE_NACK) dev_data_low = 1'b1;
          dev_clk_low = 1'b1;
          dev_pulse = 11;
          repeat (HALF) @(negedge Clock);
          dev_clk_low = 1'b0;
          repeat (2) @(negedge Clock);
          dev_data_low = 1'b0;
          repeat (HALF) @(negedge Clock);
          if (dev_mode != MODE_NOCHECK) begin
            if (exp_byte_q.size() == 0) begin
              fail_now("frame", $sformatf("unexpected frame 0x%0h", obs));
            end else begin
              b = exp_byte_q.pop_front();
              check($sformatf("frame_%02h", b), int'(obs), int'(ref_frame(b)));
              check($sformatf("parity_%02h", b), int'(obs[9]), int'(ref_frame(b) >> 9) & 1);
            end
          end
        end
        dev_pulse = 0;
        dev_active = 1'b0;
      end
    end
  end

  // Outcome monitor: every Done/Error pulse is matched against the queue.
  always @(negedge Clock) begin
    if (Reset && (Done || Error)) begin
      check("done_error_exclusive", int'(Done & Error), 0);
      if (exp_res_q.size() == 0)
        fail_now("result", $sformatf("unexpected Done=%0b Error=%0b", Done, Error));
      else
        check("result", Done ? RES_DONE : RES_ERR, exp_res_q.pop_front());
      check("busy_at_end", int'(Busy), 0);
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge Clock);
    Send = 1'b1;
    SendData = b;
    @(negedge Clock);
    Send = 1'b0;
  endtask

  // Issue an accepted transmission and record what must come out of it.
  task automatic send_frame(input logic [7:0] b, input int mode, input int res);
    dev_mode = mode;
    if (mode == MODE_ACK || mode == MODE_NACK) exp_byte_q.push_back(b);
    if (res != 0) exp_res_q.push_back(res);
    send(b);
  endtask

  // Wait for the frame to end; optionally strobe Send in the Done/Error cycle.
  task automatic wait_end(input string name, input bit poke_send);
    int t;
    t = 0;
    while (!(Done || Error) && t < 4000) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 4000) fail_now(name, "no Done/Error within 4000 cycles");
    if (poke_send) begin
      Send = 1'b1;
      SendData = 8'h55;
      @(negedge Clock);
      Send = 1'b0;
      check("send_in_done_ignored", int'(Busy), 0);
    end
    t = 0;
    while (dev_active && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 2000) fail_now(name, "device frame did not finish");
    repeat (5) @(negedge Clock);
  endtask

  task automatic wait_idle_device(input string name);
    int t;
    t = 0;
    while (dev_active && t < 4000) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 4000) fail_now(name, "device frame did not finish");
    repeat (5) @(negedge Clock);
  endtask

  initial begin : stimulus
    int t;
    logic [7:0] rb;

    // Reset state.
    repeat (3) @(negedge Clock);
    check("rst_clk_oe", int'(ps2_clk_oe), 0);
    check("rst_data_oe", int'(ps2_data_oe), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_done", int'(Done), 0);
    check("rst_error", int'(Error), 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);

    // 0xED, with a 0xFF Send issued mid-frame that must be ignored.
    send_frame(8'hED, MODE_ACK, RES_DONE);
    t = 0;
    while (dev_pulse < 3 && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    check("busy_mid_frame", int'(Busy), 1);
    send(8'hFF);
    wait_end("frame_ED", 1'b0);

    // Parity corner cases; Send strobed in the Done cycle after 0x00.
    send_frame(8'h00, MODE_ACK, RES_DONE);
    wait_end("frame_00", 1'b1);
    send_frame(8'h01, MODE_ACK, RES_DONE);
    wait_end("frame_01", 1'b0);

    // Device answers the ACK slot with data high.
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, MODE_NACK, RES_ERR);
    wait_end("frame_nack", 1'b0);
    check("nack_clk_oe", int'(ps2_clk_oe), 0);
    check("nack_data_oe", int'(ps2_data_oe), 0);

    // Device stops clocking after the 4th bit.
    rb = 8'($urandom_range(0, 255));
    send_frame(rb, MODE_STALL, RES_ERR);
    wait_end("frame_stall", 1'b0);
    check("stall_clk_oe", int'(ps2_clk_oe), 0);
    check("stall_data_oe", int'(ps2_data_oe), 0);

    // Reset in the middle of the data bits of 0x00 (data line is pulled).
    send_frame(8'h00, MODE_NOCHECK, 0);
    t = 0;
    while (dev_pulse < 5 && t < 2000) begin
      @(negedge Clock);
      t++;
    end
    if (t >= 2000) fail_now("reset_mid_xfer", "device never reached bit 5");
    #3;
    Reset = 1'b0;
    #1;
    check("reset_clk_oe", int'(ps2_clk_oe), 0);
    check("reset_data_oe", int'(ps2_data_oe), 0);
    check("reset_busy", int'(Busy), 0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    wait_idle_device("reset_mid_xfer");

    // Fresh random traffic after the reset.
    for (int i = 0; i < 5; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, MODE_ACK, RES_DONE);
      wait_end("frame_rand", 1'b0);
    end

    check("pending_frames", exp_byte_q.size(), 0);
    check("pending_results", exp_res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
